// File: rtl/fifo_pin_master.sv
// Self-test master for the TT16 nibble-FIFO pins: writes a sequential burst, drains it, counts bad reads.
// Each access is a held winc/rinc pulse plus a settle window so the divided FIFO clocks can see it.
module fifo_pin_master #(
  parameter int D_WIDTH    = 4,
  parameter int CNT_W      = 4,
  parameter int HOLD_CYC   = 4,
  parameter int SETTLE_CYC = 8,
  parameter int TIMEOUT    = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [CNT_W-1:0]   burst_len,
  input  logic [D_WIDTH-1:0] seed,
  input  logic [7:0]         dut_out,
  output logic [7:0]         dut_in,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic               timeout,
  output logic [CNT_W-1:0]   err_count,
  output logic [D_WIDTH-1:0] last_bad
);

  localparam int CW = $clog2(TIMEOUT + HOLD_CYC + SETTLE_CYC + 1);

  typedef enum logic [3:0] {
    IDLE, WR_CHECK, WR_PULSE, WR_SETTLE,
    RD_CHECK, RD_PULSE, RD_SETTLE, RD_SAMPLE, DONE
  } state_t;

  state_t state, state_nx;

  logic [CW-1:0]      cnt;
  logic [CNT_W-1:0]   len_q, wr_idx, rd_idx;
  logic [D_WIDTH-1:0] seed_q, wdata_nx, rd_exp, rdata;
  logic               full, empty, tmo_hit;
  logic [7:0]         dut_in_nx;
  logic [1:0]         unused_hi;

  assign rdata     = dut_out[D_WIDTH-1:0];
  assign full      = dut_out[4];
  assign empty     = dut_out[5];
  assign unused_hi = dut_out[7:6];
  assign rd_exp    = seed_q + D_WIDTH'(rd_idx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // cnt doubles as the stall counter in CHECK states and the hold/settle timer elsewhere
  always_comb begin
    state_nx = state;
    tmo_hit  = 1'b0;
    case (state)
      IDLE:      if (start) state_nx = (burst_len == '0) ? DONE : WR_CHECK;
      WR_CHECK: begin
        if (!full) state_nx = WR_PULSE;
        else if (cnt == CW'(TIMEOUT - 1)) begin
          tmo_hit  = 1'b1;
          state_nx = DONE;
        end
      end
      WR_PULSE:  if (cnt == CW'(HOLD_CYC - 1)) state_nx = WR_SETTLE;
      WR_SETTLE: if (cnt == CW'(SETTLE_CYC - 1))
                   state_nx = ((wr_idx + CNT_W'(1)) == len_q) ? RD_CHECK : WR_CHECK;
      RD_CHECK: begin
        if (!empty) state_nx = RD_PULSE;
        else if (cnt == CW'(TIMEOUT - 1)) begin
          tmo_hit  = 1'b1;
          state_nx = DONE;
        end
      end
      RD_PULSE:  if (cnt == CW'(HOLD_CYC - 1)) state_nx = RD_SETTLE;
      RD_SETTLE: if (cnt == CW'(SETTLE_CYC - 1)) state_nx = RD_SAMPLE;
      RD_SAMPLE: state_nx = ((rd_idx + CNT_W'(1)) == len_q) ? DONE : RD_CHECK;
      DONE:      state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase

    // pins are registered from the next state so winc/rinc align exactly with the pulse states
    wdata_nx  = seed_q + D_WIDTH'(wr_idx);
    dut_in_nx = '0;
    case (state_nx)
      WR_PULSE:  dut_in_nx = {2'b00, 1'b0, 1'b1, wdata_nx};
      WR_SETTLE: dut_in_nx = {2'b00, 1'b0, 1'b0, wdata_nx};
      RD_PULSE:  dut_in_nx = 8'h20;
      default:   dut_in_nx = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dut_in    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      timeout   <= 1'b0;
      err_count <= '0;
      last_bad  <= '0;
      cnt       <= '0;
      len_q     <= '0;
      seed_q    <= '0;
      wr_idx    <= '0;
      rd_idx    <= '0;
    end else begin
      dut_in <= dut_in_nx;
      done   <= (state == DONE);
      cnt    <= (state_nx != state) ? '0 : cnt + 1'b1;
      case (state)
        IDLE: if (start) begin
          len_q     <= burst_len;
          seed_q    <= seed;
          wr_idx    <= '0;
          rd_idx    <= '0;
          err_count <= '0;
          timeout   <= 1'b0;
          pass      <= 1'b0;
          busy      <= 1'b1;
        end
        WR_SETTLE: if (state_nx != WR_SETTLE) wr_idx <= wr_idx + 1'b1;
        RD_SAMPLE: begin
          rd_idx <= rd_idx + 1'b1;
          if (rdata != rd_exp) begin
            if (err_count != '1) err_count <= err_count + 1'b1;
            last_bad <= rdata;
          end
        end
        DONE: begin
          busy <= 1'b0;
          pass <= (err_count == '0) && !timeout;
        end
        default: ;
      endcase
      if (tmo_hit) timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_pin_master.sv
// Bench for fifo_pin_master: ideal depth-8 nibble FIFO on the pins, queue-based scoreboard for writes and run results.
module tb_fifo_pin_master;
  localparam int HOLD = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] burst_len = '0;
  logic [3:0] seed = '0;
  logic [7:0] dut_out, dut_in;
  logic       busy, done, pass, timeout;
  logic [3:0] err_count, last_bad;

  fifo_pin_master dut (
    .clk(clk), .rst_n(rst_n), .start(start), .burst_len(burst_len), .seed(seed),
    .dut_out(dut_out), .dut_in(dut_in), .busy(busy), .done(done), .pass(pass),
    .timeout(timeout), .err_count(err_count), .last_bad(last_bad)
  );

  always #5 clk = ~clk;

  typedef struct {
    int lat; int pass; int tmo; int errs; int lbad; int reads;
  } exp_t;

  exp_t       exp_done[$];
  logic [3:0] exp_wr[$];
  int total = 0, bad = 0, cyc = 0, start_cyc = 0, done_cnt = 0, wait_req = 0, fin_req = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // ideal FIFO: a winc rise pushes wdata, a rinc rise pops into the registered rdata
  logic [3:0] mem [8];
  int         fcount = 0, wp = 0, rp = 0, rd_num = 0;
  logic [3:0] rdata_q = '0;
  logic       winc_d = 1'b0, rinc_d = 1'b0, force_full = 1'b0;
  int         corrupt_idx = -1;

  assign dut_out = {2'b00, fcount == 0, (fcount == 8) || force_full, rdata_q};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcount <= 0; wp <= 0; rp <= 0; rd_num <= 0;
      rdata_q <= '0; winc_d <= 1'b0; rinc_d <= 1'b0;
    end else begin
      winc_d <= dut_in[4];
      rinc_d <= dut_in[5];
      if (dut_in[4] && !winc_d && fcount < 8) begin
        mem[wp] <= dut_in[3:0];
        wp      <= (wp + 1) % 8;
        fcount  <= fcount + 1;
      end else if (dut_in[5] && !rinc_d && fcount > 0) begin
        rdata_q <= (rd_num == corrupt_idx) ? (mem[rp] ^ 4'h1) : mem[rp];
        rp      <= (rp + 1) % 8;
        fcount  <= fcount - 1;
        rd_num  <= rd_num + 1;
      end
    end
  end

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // monitor: all comparisons happen here, on the falling clock edge or right after an async reset
  int         wlen = 0, rlen = 0, rd_seen = 0, wait_ack = 0;
  logic       wprev = 1'b0, rprev = 1'b0, full_prev = 1'b0, rst_prev = 1'b0;
  logic       idle_chk = 1'b1, fin_done = 1'b0;
  exp_t       mx;
  logic [3:0] mw;

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if (rst_prev) begin
        #1;
        chk("async_rst_dut_in", dut_in, 0);
        chk("async_rst_busy", busy, 0);
        exp_wr.delete();
        exp_done.delete();
      end
      rst_prev = 1'b0; idle_chk = 1'b1; wlen = 0; rlen = 0; rd_seen = 0;
      wprev = 1'b0; rprev = 1'b0; full_prev = 1'b0;
    end else begin
      rst_prev = 1'b1;
      if (idle_chk) begin
        chk("rst_dut_in", dut_in, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_err_count", err_count, 0);
        chk("rst_last_bad", last_bad, 0);
        idle_chk = 1'b0;
      end
      if (dut_in[4]) begin
        if (!wprev) begin
          chk("write_while_full", full_prev, 0);
          chk("winc_rinc_overlap", dut_in[5], 0);
          if (exp_wr.size() == 0) chk("unexpected_write", 1, 0);
          else begin
            mw = exp_wr.pop_front();
            chk("wdata", dut_in[3:0], mw);
          end
          wlen = 0;
        end
        wlen++;
      end else if (wprev) chk("winc_width", wlen, HOLD);
      wprev = dut_in[4];
      if (dut_in[5]) begin
        if (!rprev) begin
          chk("rinc_wdata_zero", dut_in[4:0], 0);
          rd_seen++;
          rlen = 0;
        end
        rlen++;
      end else if (rprev) chk("rinc_width", rlen, HOLD);
      rprev = dut_in[5];
      if (done) begin
        done_cnt++;
        if (exp_done.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          mx = exp_done.pop_front();
          if (mx.lat >= 0) chk("done_latency", cyc - start_cyc, mx.lat);
          chk("pass", pass, mx.pass);
          chk("timeout", timeout, mx.tmo);
          chk("err_count", err_count, mx.errs);
          chk("last_bad", last_bad, mx.lbad);
          chk("read_count", rd_seen, mx.reads);
          chk("busy_at_done", busy, 0);
          chk("dut_in_at_done", dut_in, 0);
          chk("writes_left", exp_wr.size(), 0);
        end
        rd_seen = 0;
      end
      full_prev = dut_out[4];
      while (wait_ack != wait_req) begin
        chk("wait_budget_expired", 1, 0);
        wait_ack++;
      end
      if (fin_req != 0 && !fin_done) begin
        chk("runs_left", exp_done.size(), 0);
        fin_done = 1'b1;
      end
    end
  end

  task automatic launch(input logic [3:0] s, input logic [3:0] n, input int nwr, input int lat,
                        input int p, input int t, input int e, input int lb, input int rd);
    exp_t x;
    for (int i = 0; i < nwr; i++) exp_wr.push_back(4'(s + i));
    x.lat = lat; x.pass = p; x.tmo = t; x.errs = e; x.lbad = lb; x.reads = rd;
    exp_done.push_back(x);
    @(posedge clk); #1;
    seed = s; burst_len = n; start = 1'b1; start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0; seed = '0; burst_len = '0;
  endtask

  task automatic wait_done(input int budget);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < budget && done_cnt == d0; i++) @(posedge clk);
    if (done_cnt == d0) wait_req++;
    repeat (3) @(posedge clk);
  endtask

  task automatic wait_winc(input int budget);
    int seen;
    seen = 0;
    for (int i = 0; i < budget && seen == 0; i++) begin
      @(posedge clk); #1;
      if (dut_in[4]) seen = 1;
    end
    if (seen == 0) wait_req++;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);

    // basic run: writes 3..7, 137 cycles start to done
    launch(4'd3, 4'd5, 5, 137, 1, 0, 0, 0, 5);
    wait_done(300);

    // wrap E,F,0,1 with a start pulse while busy that must be ignored
    launch(4'd14, 4'd4, 4, 110, 1, 0, 0, 0, 4);
    repeat (30) @(posedge clk);
    #1 start = 1'b1; seed = 4'd0; burst_len = 4'd1;
    @(posedge clk); #1 start = 1'b0; burst_len = '0;
    wait_done(300);

    // full held for 20 cycles after the first write: stall then finish cleanly
    launch(4'd3, 4'd5, 5, -1, 1, 0, 0, 0, 5);
    wait_winc(50);
    repeat (2) @(posedge clk);
    #1 force_full = 1'b1;
    repeat (20) @(posedge clk);
    #1 force_full = 1'b0;
    wait_done(400);

    // full never clears: abort after 64 stall cycles
    @(posedge clk); #1 force_full = 1'b1;
    launch(4'd3, 4'd5, 0, 66, 0, 1, 0, 0, 0);
    wait_done(200);
    @(posedge clk); #1 force_full = 1'b0;

    // second read comes back as 5 instead of 4
    corrupt_idx = rd_num + 1;
    launch(4'd3, 4'd5, 5, 137, 0, 0, 1, 5, 5);
    wait_done(300);
    corrupt_idx = -1;

    // zero-length burst
    launch(4'd7, 4'd0, 0, 2, 1, 0, 0, 5, 0);
    wait_done(20);

    // reset during the first write pulse, then a clean rerun
    launch(4'd3, 4'd5, 5, 137, 1, 0, 0, 0, 5);
    wait_winc(50);
    @(posedge clk); #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    launch(4'd3, 4'd5, 5, 137, 1, 0, 0, 0, 5);
    wait_done(300);

    fin_req = 1;
    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_pin_master.md
Name: fifo_pin_master

Overview:
- Single-clock stimulus/checker that drives the far side of the TT16 nibble-FIFO pin interface.
- Drives ui_in: wdata[3:0], winc on bit 4, rinc on bit 5.
- Observes uo_out: rdata[3:0], full on bit 4, empty on bit 5.
- On start it pushes a burst of sequential nibbles, honouring full, then drains the same count, honouring empty, and checks each read word against the expected sequence.
- Used as an on-chip self-test master and as the bench-side host driver.

Parameters:
D_WIDTH, 4, data nibble width; fixed by the pin map.
CNT_W, 4, width of burst length and error counter.
HOLD_CYC, 4, clk cycles winc/rinc is held high per access; covers the divided FIFO clocks.
SETTLE_CYC, 8, clk cycles after a pulse before status/rdata are trusted.
TIMEOUT, 64, max consecutive stall cycles on full/empty before abort.

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
start  in  1  one-cycle request; sampled only in IDLE
burst_len  in  CNT_W  words to write then read; sampled on start
seed  in  D_WIDTH  first data value; sampled on start
dut_out  in  8  FIFO-top status: [3:0] rdata, [4] full, [5] empty, [7:6] ignored
dut_in  out  8  FIFO-top inputs: [3:0] wdata, [4] winc, [5] rinc, [7:6] always 0
busy  out  1  high from the cycle after an accepted start until DONE
done  out  1  one-cycle pulse at end of run
pass  out  1  1 = no mismatch and no timeout; held until the next accepted start
timeout  out  1  run aborted on a stall; held until the next accepted start
err_count  out  CNT_W  mismatching reads, saturating at all-ones
last_bad  out  D_WIDTH  rdata value of the most recent mismatching read

Behaviour:
- Reset (asynchronous) values: state IDLE, dut_in=0, busy=0, done=0, pass=0, timeout=0, err_count=0, last_bad=0. Reset mid-run aborts immediately; no pulse is completed.
- All outputs are registered. dut_in changes only on clk edges.
- States and per-state actions:
  - IDLE: on start, latch burst_len and seed, clear wr_idx/rd_idx/err_count/timeout/pass. Go to DONE if burst_len=0, else WR_CHECK.
  - WR_CHECK: if full=1, stay and increment the stall counter. Else go to WR_PULSE with wdata = seed+wr_idx (mod 16).
  - WR_PULSE: winc=1 for exactly HOLD_CYC cycles, wdata stable throughout, then WR_SETTLE.
  - WR_SETTLE: winc=0 and wdata held for SETTLE_CYC cycles. Then wr_idx++. Go to RD_CHECK if wr_idx==burst_len, else WR_CHECK.
  - RD_CHECK: if empty=1, stall as in WR_CHECK. Else go to RD_PULSE.
  - RD_PULSE: rinc=1 for HOLD_CYC cycles.
  - RD_SETTLE: rinc=0 for SETTLE_CYC cycles.
  - RD_SAMPLE: 1 cycle. Compare dut_out[3:0] with seed+rd_idx (mod 16). On mismatch, err_count++ (saturating) and last_bad=rdata. Then rd_idx++. Go to DONE if rd_idx==burst_len, else RD_CHECK.
  - DONE: 1 cycle. done=1, busy=0, pass=(err_count==0)&~timeout. Then IDLE.
- Stall counter: cleared on every exit from a CHECK state. On reaching TIMEOUT, set timeout=1, force dut_in=0 and go to DONE.
- Access timing: winc and rinc are never high in the same cycle. Write = 1+HOLD_CYC+SETTLE_CYC cycles (13 at defaults). Read = 2+HOLD_CYC+SETTLE_CYC cycles (14 at defaults), excluding stalls.
- start while busy is ignored. wdata is driven 0 outside the write states.
- Arithmetic: data index is modulo 2^D_WIDTH, so the sequence wraps F→0. burst_len up to 2^CNT_W−1.

Test Plan:
1. Ideal FIFO model (depth 8), seed=3, burst_len=5 -> winc pulses carry 3,4,5,6,7; reads match; done at 1+5*13+5*14+1=137 cycles after start; pass=1, err_count=0.
2. seed=14, burst_len=4 -> written/expected sequence E,F,0,1; pass=1.
3. Model holds full=1 for 20 cycles before the 2nd write -> no winc during the stall, run completes with pass=1. Full held 64 cycles -> timeout=1, pass=0, dut_in=0, done pulse.
4. Model returns rdata^1 on the 2nd read (seed=3, so 5 instead of 4) -> err_count=1, last_bad=5, pass=0.
5. burst_len=0 -> done pulses 2 cycles after start, no winc/rinc ever high, pass=1; start asserted while busy=1 is ignored.
6. rst_n low during WR_PULSE -> dut_in=0 and busy=0 immediately (asynchronously); after release, a new start runs test 1 cleanly.
